lcd_ddram_capture: RTL and testbench

Receiving-end model of the HD44780-style character LCD bus driven by the display writer. It samples enable/rs/rw/lcd_data, latches each transfer on the enable falling edge, and decodes commands and character writes into an 80-byte DDRAM image. The image is readable through a synchronous port, and per-write events are reported. It sits in the KPN output-path bench and the on-chip debug path, replacing the physical panel.

---
 rtl/lcd_ddram_capture.sv | 136 +++++++++++++
 tb/tb_lcd_ddram_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ddram_capture.sv
// HD44780-style LCD bus receiver: latches transfers on the enable falling edge,
// decodes commands and character writes into an 80-byte DDRAM image with readback.
module lcd_ddram_capture #(
  parameter int BUSY_CYCLES  = 1,
  parameter int CLEAR_CYCLES = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_rs,
  input  logic        i_rw,
  input  logic [7:0]  i_lcd_data,
  input  logic        i_on,
  input  logic [6:0]  i_rd_addr,
  output logic [7:0]  o_rd_data,
  output logic [6:0]  o_cursor_address,
  output logic        o_busy,
  output logic        o_char_valid,
  output logic [6:0]  o_char_addr,
  output logic [7:0]  o_char_code,
  output logic        o_overrun,
  output logic        o_bad_addr,
  output logic [15:0] o_write_count
);

  localparam int MAXC = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLR_LD  = CW'(CLEAR_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Second line (0x40..0x67) packs directly after the first 40 bytes.
  function automatic logic [6:0] addr_idx(input logic [6:0] a);
    return a[6] ? (a - 7'd24) : a;
  endfunction

  function automatic logic [6:0] addr_next(input logic [6:0] a);
    if (a == 7'h27) return 7'h40;
    if (a == 7'h67) return 7'h00;
    return a + 7'd1;
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_en_q;
  logic [7:0]      r_ddram [80];
  logic [7:0]      r_rd_data;
  logic [6:0]      r_cursor;
  logic            r_char_valid;
  logic [6:0]      r_char_addr;
  logic [7:0]      r_char_code;
  logic            r_overrun;
  logic            r_bad_addr;
  logic [15:0]     r_write_count;
  logic            w_strobe;

  assign w_strobe = r_en_q & ~i_enable & i_on;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_en_q        <= 1'b0;
      for (int i = 0; i < 80; i++) r_ddram[i] <= 8'h20;
      r_rd_data     <= 8'h00;
      r_cursor      <= 7'h00;
      r_char_valid  <= 1'b0;
      r_char_addr   <= 7'h00;
      r_char_code   <= 8'h00;
      r_overrun     <= 1'b0;
      r_bad_addr    <= 1'b0;
      r_write_count <= 16'h0000;
    end else begin
      r_en_q       <= i_enable;
      r_char_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_bad_addr   <= 1'b0;
      r_rd_data    <= addr_ok(i_rd_addr) ? r_ddram[addr_idx(i_rd_addr)] : 8'h00;

      case (r_state)
        S_IDLE: ;
        S_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Acceptance uses the pre-edge state, so a strobe on the final busy edge is rejected.
      if (w_strobe) begin
        if ((r_state == S_BUSY) || i_rw) begin
          r_overrun <= 1'b1;
        end else begin
          r_state <= S_BUSY;
          r_cnt   <= BUSY_LD;
          if (!i_rs) begin
            if (i_lcd_data == 8'h01) begin
              for (int i = 0; i < 80; i++) r_ddram[i] <= 8'h20;
              r_cursor      <= 7'h00;
              r_write_count <= 16'h0000;
              r_cnt         <= CLR_LD;
            end else if (i_lcd_data[7:1] == 7'h01) begin
              r_cursor <= 7'h00;
            end else if (i_lcd_data[7]) begin
              if (addr_ok(i_lcd_data[6:0])) r_cursor   <= i_lcd_data[6:0];
              else                          r_bad_addr <= 1'b1;
            end
          end else begin
            r_ddram[addr_idx(r_cursor)] <= i_lcd_data;
            r_char_valid  <= 1'b1;
            r_char_addr   <= r_cursor;
            r_char_code   <= i_lcd_data;
            r_cursor      <= addr_next(r_cursor);
            if (r_write_count != 16'hFFFF) r_write_count <= r_write_count + 16'd1;
          end
        end
      end
    end
  end

  assign o_rd_data        = r_rd_data;
  assign o_cursor_address = r_cursor;
  assign o_busy           = (r_state == S_BUSY);
  assign o_char_valid     = r_char_valid;
  assign o_char_addr      = r_char_addr;
  assign o_char_code      = r_char_code;
  assign o_overrun        = r_overrun;
  assign o_bad_addr       = r_bad_addr;
  assign o_write_count    = r_write_count;

endmodule

// File: tb/tb_lcd_ddram_capture.sv
// Randomized + directed bench for lcd_ddram_capture against an address-level
// model of the display (raw-address byte map, ready-cycle busy bookkeeping).
module tb_lcd_ddram_capture;
  localparam int BC = 3;
  localparam int CC = 5;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, rs = 1'b0, rw = 1'b0, pwr = 1'b1;
  logic [7:0]  d = 8'h00;
  logic [6:0]  rda = 7'h00;
  logic [7:0]  rd_data, char_code;
  logic [6:0]  cursor, char_addr;
  logic        busy, char_valid, overrun, bad_addr;
  logic [15:0] wcount;

  lcd_ddram_capture #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_rs(rs), .i_rw(rw),
    .i_lcd_data(d), .i_on(pwr), .i_rd_addr(rda), .o_rd_data(rd_data),
    .o_cursor_address(cursor), .o_busy(busy), .o_char_valid(char_valid),
    .o_char_addr(char_addr), .o_char_code(char_code), .o_overrun(overrun),
    .o_bad_addr(bad_addr), .o_write_count(wcount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: memory keyed by raw DDRAM address; busy as "first edge that may accept".
  byte unsigned m [128];
  int  m_cur, m_cnt, rdy, e_ca, e_cc;
  bit  e_cv, e_ov, e_ba;

  function automatic bit vld(input int a);
    return (a >= 0 && a <= 39) || (a >= 64 && a <= 103);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m[i] = 8'h20;
    m_cur = 0; m_cnt = 0; rdy = 0; e_cv = 0; e_ov = 0; e_ba = 0;
  endtask

  task automatic m_step(input bit rs_, input bit rw_, input int d_, input bit p_, input int t);
    int L;
    e_cv = 0; e_ov = 0; e_ba = 0;
    if (!p_) return;
    if (t < rdy || rw_) begin e_ov = 1; return; end
    L = BC;
    if (!rs_) begin
      if (d_ == 1) begin
        for (int i = 0; i < 128; i++) m[i] = 8'h20;
        m_cur = 0; m_cnt = 0; L = CC;
      end else if (d_ == 2 || d_ == 3) m_cur = 0;
      else if (d_ >= 128) begin
        if (vld(d_ - 128)) m_cur = d_ - 128; else e_ba = 1;
      end
    end else begin
      m[m_cur] = byte'(d_);
      e_cv = 1; e_ca = m_cur; e_cc = d_;
      if (m_cnt < 65535) m_cnt++;
      m_cur = (m_cur == 39) ? 64 : (m_cur == 103) ? 0 : m_cur + 1;
    end
    rdy = t + L + 1;
  endtask

  function automatic int exp_rd(input int a);
    return vld(a) ? int'(m[a]) : 0;
  endfunction

  task automatic state_chk(input string pfx);
    chk({pfx, "_busy"},   busy,   cyc < rdy - 1);
    chk({pfx, "_cursor"}, cursor, m_cur);
    chk({pfx, "_wcount"}, wcount, m_cnt);
  endtask

  // One bus transfer; strobe edge lands two clocks after the starting negedge.
  task automatic xfer(input bit rs_, input bit rw_, input logic [7:0] d_, input bit p_,
                      input int gap, input bit wt);
    @(negedge clk);
    if (wt) while (cyc + 2 < rdy) @(negedge clk);
    repeat (gap) @(negedge clk);
    en = 1; rs = rs_; rw = rw_; d = d_; pwr = 1; rda = 7'($urandom_range(0, 127));
    @(negedge clk);
    chk("pulse_lo", {char_valid, overrun, bad_addr}, 3'b000);
    en = 0; pwr = p_;
    @(posedge clk); #1;
    chk("rd_data", rd_data, exp_rd(int'(rda)));
    m_step(rs_, rw_, int'(d_), p_, cyc);
    chk("char_valid", char_valid, e_cv);
    chk("overrun", overrun, e_ov);
    chk("bad_addr", bad_addr, e_ba);
    if (e_cv) begin
      chk("char_addr", char_addr, e_ca);
      chk("char_code", char_code, e_cc);
    end
    state_chk("post");
  endtask

  task automatic rdchk(input logic [6:0] a);
    @(negedge clk);
    rda = a; pwr = 1;
    @(posedge clk); #1;
    chk("rdchk", rd_data, exp_rd(int'(a)));
    chk("idle_pulse", {char_valid, overrun, bad_addr}, 3'b000);
    state_chk("idle");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] dd;
    int k;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_wcount", wcount, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_pulses", {char_valid, overrun, bad_addr}, 3'b000);
    rst = 0;
    rdchk(7'h00); rdchk(7'h67); rdchk(7'h30);
    chk("rst_img", rd_data, 8'h00);

    // Clear, home to 0, write "KPN"
    xfer(0, 0, 8'h01, 1, 0, 1);
    xfer(0, 0, 8'h80, 1, 0, 1);
    xfer(1, 0, 8'h4B, 1, 0, 1);
    xfer(1, 0, 8'h50, 1, 0, 1);
    xfer(1, 0, 8'h4E, 1, 0, 1);
    rdchk(7'h00); chk("kpn_0", rd_data, 8'h4B);
    rdchk(7'h01); rdchk(7'h02); chk("kpn_2", rd_data, 8'h4E);
    chk("kpn_cursor", cursor, 7'h03);
    chk("kpn_wcount", wcount, 16'd3);

    // Line-1 end wraps to line-2 start
    xfer(0, 0, 8'hA7, 1, 0, 1);
    xfer(1, 0, 8'h31, 1, 0, 1);
    chk("wrap_a0", char_addr, 7'h27);
    xfer(1, 0, 8'h32, 1, 0, 1);
    chk("wrap_a1", char_addr, 7'h40);
    chk("wrap_cursor", cursor, 7'h41);
    rdchk(7'h27); rdchk(7'h40);
    // Line-2 end wraps to 0
    xfer(0, 0, 8'hE7, 1, 0, 1);
    xfer(1, 0, 8'h33, 1, 0, 1);
    chk("wrap_home", cursor, 7'h00);

    // Busy overrun, and the edge where the counter reaches zero
    xfer(1, 0, 8'h41, 1, 0, 1);
    xfer(1, 0, 8'h42, 1, 0, 0);
    chk("ovr_pulse", overrun, 1);
    xfer(1, 0, 8'h43, 1, 0, 1);
    xfer(1, 0, 8'h44, 1, 1, 0);
    chk("ovr_last_edge", overrun, 1);
    xfer(1, 0, 8'h45, 1, 0, 1);
    xfer(1, 0, 8'h46, 1, 2, 0);
    chk("acc_after_busy", char_valid, 1);

    // Bad address, read strobe, power off
    xfer(0, 0, 8'hB0, 1, 0, 1);
    chk("bad_pulse", bad_addr, 1);
    xfer(0, 1, 8'h80, 1, 0, 1);
    chk("rw_ovr", overrun, 1);
    xfer(1, 0, 8'h5A, 0, 0, 1);
    chk("off_ignored", char_valid, 0);
    xfer(0, 0, 8'h02, 1, 0, 1);

    // Five chars then clear
    for (int i = 0; i < 5; i++) xfer(1, 0, 8'h61 + 8'(i), 1, 0, 1);
    xfer(0, 0, 8'h01, 1, 0, 1);
    for (int i = 0; i < 6; i++) rdchk(7'(i));
    chk("clr_cursor", cursor, 0);
    chk("clr_wcount", wcount, 0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 3) != 0) dd = 8'($urandom);
      else if (k == 0) dd = 8'h01;
      else if (k <= 2) dd = 8'h02 + 8'(k - 1);
      else if (k <= 6) dd = 8'h80 | 8'($urandom_range(0, 127));
      else dd = 8'($urandom_range(0, 127));
      if (dd[7] == 1'b0 && dd > 8'h03 && $urandom_range(0, 3) != 0) begin
        xfer(1, $urandom_range(0, 9) == 0, dd, $urandom_range(0, 9) != 0,
             $urandom_range(0, 3), $urandom_range(0, 1));
      end else begin
        xfer(0, $urandom_range(0, 9) == 0, dd, $urandom_range(0, 9) != 0,
             $urandom_range(0, 3), $urandom_range(0, 1));
      end
      if ($urandom_range(0, 4) == 0) rdchk(7'($urandom_range(0, 127)));
    end

    // Reset in the middle of a clear's busy period
    xfer(0, 0, 8'h01, 1, 0, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cursor", cursor, 0);
    @(negedge clk);
    rst = 0;
    m_reset();
    rdchk(7'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
